// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings and types for the data-memory arbiter.
// Optional build macro used by the arbiter: DMEM_ARB_STATS_EN.
// SIZE_ADDR / SIZE_DATA default here when no sizes header set them first.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

package dmem_arb_pkg;

  // FSM state encodings
  localparam logic [0:0] S_CORE  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;

  // Owner tag encodings for the read response path
  localparam logic [0:0] OWN_CORE = 1'b0;
  localparam logic [0:0] OWN_EXT  = 1'b1;

  // One memory-port command: write enable, address, write data
  typedef struct packed {
    logic                  we;
    logic [`SIZE_ADDR-1:0] addr;
    logic [`SIZE_DATA-1:0] wdata;
  } mem_req_t;

  // Saturating increment for data-width statistics counters
  function automatic logic [`SIZE_DATA-1:0] sat_inc_data(input logic [`SIZE_DATA-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// dmem_arb_resp: registered read-response router.
// Remembers who was granted a read and steers the memory's next-cycle read
// data to that owner. Each rdata output holds its last delivered value.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dmem_arb_resp
  import dmem_arb_pkg::*;
(
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_grant_rd,
  input  logic [0:0]            iw_grant_own,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata,
  output logic                  or_core_rvalid,
  output logic [`SIZE_DATA-1:0] or_core_rdata,
  output logic                  or_ext_rvalid,
  output logic [`SIZE_DATA-1:0] or_ext_rdata
);

  logic                  rd_q;
  logic [0:0]            own_q;
  logic [`SIZE_DATA-1:0] core_hold_q;
  logic [`SIZE_DATA-1:0] ext_hold_q;
  logic                  core_hit;
  logic                  ext_hit;

  // Capture read flag and owner of the access granted this cycle
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      rd_q  <= 1'b0;
      own_q <= OWN_CORE;
    end else begin
      rd_q <= iw_grant_rd;
      if (iw_grant_rd) own_q <= iw_grant_own;
    end
  end

  assign core_hit = rd_q && (own_q == OWN_CORE);
  assign ext_hit  = rd_q && (own_q == OWN_EXT);

  // Keep the last delivered word per owner so rdata holds between responses
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      core_hold_q <= '0;
      ext_hold_q  <= '0;
    end else begin
      if (core_hit) core_hold_q <= iw_mem_rdata;
      if (ext_hit)  ext_hold_q  <= iw_mem_rdata;
    end
  end

  assign or_core_rvalid = core_hit;
  assign or_ext_rvalid  = ext_hit;
  assign or_core_rdata  = core_hit ? iw_mem_rdata : core_hold_q;
  assign or_ext_rdata   = ext_hit  ? iw_mem_rdata : ext_hold_q;

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: one data-memory port shared by the core (priority) and an
// external requester, with a starvation counter that force-grants the
// external side after STARVE_LIM lost conflict cycles.
// External handshake: a transfer happens in a cycle where iw_ext_valid and
// ow_ext_ready are both 1; the requester holds valid/we/addr/wdata until then.
// Optional build macro: DMEM_ARB_STATS_EN adds conflict/force statistics.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_core_req,
  input  logic                  iw_core_we,
  input  logic [`SIZE_ADDR-1:0] iw_core_addr,
  input  logic [`SIZE_DATA-1:0] iw_core_wdata,
  output logic                  ow_core_stall,
  output logic                  or_core_rvalid,
  output logic [`SIZE_DATA-1:0] or_core_rdata,
  input  logic                  iw_ext_valid,
  input  logic                  iw_ext_we,
  input  logic [`SIZE_ADDR-1:0] iw_ext_addr,
  input  logic [`SIZE_DATA-1:0] iw_ext_wdata,
  output logic                  ow_ext_ready,
  output logic                  or_ext_rvalid,
  output logic [`SIZE_DATA-1:0] or_ext_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [`SIZE_DATA-1:0] or_stat_conflicts,
  output logic [`SIZE_DATA-1:0] or_stat_forces,
`endif
  output logic                  ow_mem_we,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr,
  output logic [`SIZE_DATA-1:0] ow_mem_wdata,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_core;
  logic             grant_ext;
  logic             conflict;
  logic             force_grant;
  mem_req_t         mem_req;

  // Grant decision, next state and starvation counter update
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_core    = 1'b0;
    grant_ext     = 1'b0;
    conflict      = 1'b0;
    force_grant   = 1'b0;
    ow_core_stall = 1'b0;
    ow_ext_ready  = 1'b0;
    if (state_q == S_FORCE) begin
      // One-shot external grant; if the request vanished nobody is granted
      state_d = S_CORE;
      cnt_d   = '0;
      if (iw_ext_valid) begin
        grant_ext     = 1'b1;
        force_grant   = 1'b1;
        ow_ext_ready  = 1'b1;
        ow_core_stall = iw_core_req;
      end
    end else if (iw_core_req && iw_ext_valid) begin
      // Core wins; the counter saturates at the limit and triggers the force
      grant_core = 1'b1;
      conflict   = 1'b1;
      if (cnt_q == CNT_LIM) state_d = S_FORCE;
      else                  cnt_d   = cnt_q + 1'b1;
    end else if (iw_core_req) begin
      grant_core = 1'b1;
    end else if (iw_ext_valid) begin
      grant_ext    = 1'b1;
      ow_ext_ready = 1'b1;
      cnt_d        = '0;
    end
  end

  // FSM state and starvation counter registers
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= S_CORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory port mux: granted requester's command, all zero when idle
  always_comb begin
    mem_req = '0;
    if (grant_core) begin
      mem_req.we    = iw_core_we;
      mem_req.addr  = iw_core_addr;
      mem_req.wdata = iw_core_wdata;
    end else if (grant_ext) begin
      mem_req.we    = iw_ext_we;
      mem_req.addr  = iw_ext_addr;
      mem_req.wdata = iw_ext_wdata;
    end
  end

  assign ow_mem_we    = mem_req.we;
  assign ow_mem_addr  = mem_req.addr;
  assign ow_mem_wdata = mem_req.wdata;

  dmem_arb_resp u_resp (
    .iw_clk         (iw_clk),
    .iw_rst         (iw_rst),
    .iw_grant_rd    ((grant_core && !iw_core_we) || (grant_ext && !iw_ext_we)),
    .iw_grant_own   (grant_ext ? OWN_EXT : OWN_CORE),
    .iw_mem_rdata   (iw_mem_rdata),
    .or_core_rvalid (or_core_rvalid),
    .or_core_rdata  (or_core_rdata),
    .or_ext_rvalid  (or_ext_rvalid),
    .or_ext_rdata   (or_ext_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  // Saturating counts of conflict cycles and forced external grants
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      or_stat_conflicts <= '0;
      or_stat_forces    <= '0;
    end else begin
      if (conflict)    or_stat_conflicts <= sat_inc_data(or_stat_conflicts);
      if (force_grant) or_stat_forces    <= sat_inc_data(or_stat_forces);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed self-checking bench for dmem_arb with a small
// synchronous-read memory model on the arbitrated port.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_dmem_arb;

  logic                  clk;
  logic                  rst;
  logic                  core_req;
  logic                  core_we;
  logic [`SIZE_ADDR-1:0] core_addr;
  logic [`SIZE_DATA-1:0] core_wdata;
  logic                  core_stall;
  logic                  core_rvalid;
  logic [`SIZE_DATA-1:0] core_rdata;
  logic                  ext_valid;
  logic                  ext_we;
  logic [`SIZE_ADDR-1:0] ext_addr;
  logic [`SIZE_DATA-1:0] ext_wdata;
  logic                  ext_ready;
  logic                  ext_rvalid;
  logic [`SIZE_DATA-1:0] ext_rdata;
  logic                  mem_we;
  logic [`SIZE_ADDR-1:0] mem_addr;
  logic [`SIZE_DATA-1:0] mem_wdata;
  logic [`SIZE_DATA-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [`SIZE_DATA-1:0] stat_conflicts;
  logic [`SIZE_DATA-1:0] stat_forces;
`endif

  logic [`SIZE_DATA-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  dmem_arb #(.STARVE_LIM(4), .CNT_W(4)) dut (
    .iw_clk            (clk),
    .iw_rst            (rst),
    .iw_core_req       (core_req),
    .iw_core_we        (core_we),
    .iw_core_addr      (core_addr),
    .iw_core_wdata     (core_wdata),
    .ow_core_stall     (core_stall),
    .or_core_rvalid    (core_rvalid),
    .or_core_rdata     (core_rdata),
    .iw_ext_valid      (ext_valid),
    .iw_ext_we         (ext_we),
    .iw_ext_addr       (ext_addr),
    .iw_ext_wdata      (ext_wdata),
    .ow_ext_ready      (ext_ready),
    .or_ext_rvalid     (ext_rvalid),
    .or_ext_rdata      (ext_rdata),
`ifdef DMEM_ARB_STATS_EN
    .or_stat_conflicts (stat_conflicts),
    .or_stat_forces    (stat_forces),
`endif
    .ow_mem_we         (mem_we),
    .ow_mem_addr       (mem_addr),
    .ow_mem_wdata      (mem_wdata),
    .iw_mem_rdata      (mem_rdata)
  );

  // Clock and synchronous-read memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic test_reset();
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ext_valid = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", core_stall); end
    checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ext_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (core_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b exp 00", core_rvalid, ext_rvalid); end
    checks++; if (core_rdata !== '0 || ext_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", core_rdata, ext_rdata); end
  endtask

  task automatic test_core_rw();
    // Core write 0xAB to 0x10: write must not raise rvalid
    @(negedge clk);
    core_req = 1; core_we = 1; core_addr = 'h10; core_wdata = 'hAB;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL core_wr_stall got %b exp 0", core_stall); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 'hAB) begin errors++; $display("FAIL core_wr_mem got we=%b wd=%h exp 1/ab", mem_we, mem_wdata); end
    // Core read of 0x10
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_wr_rvalid got %b exp 0", core_rvalid); end
    core_we = 0; core_wdata = '0;
    #1;
    checks++; if (core_stall !== 1'b0 || mem_addr !== 'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL core_rd_cmd got stall=%b addr=%h we=%b exp 0/10/0", core_stall, mem_addr, mem_we); end
    @(negedge clk);
    core_req = 0;
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 'hAB) begin errors++; $display("FAIL core_rd_data got v=%b d=%h exp 1/ab", core_rvalid, core_rdata); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL core_rd_ext_rvalid got %b exp 0", ext_rvalid); end
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== 'hAB) begin errors++; $display("FAIL core_rd_hold got v=%b d=%h exp 0/ab", core_rvalid, core_rdata); end
  endtask

  task automatic test_ext_rw();
    @(negedge clk);
    ext_valid = 1; ext_we = 1; ext_addr = 'h20; ext_wdata = 'h55;
    #1;
    checks++; if (ext_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 'h20 || mem_wdata !== 'h55) begin errors++; $display("FAIL ext_wr got rdy=%b we=%b a=%h d=%h exp 1/1/20/55", ext_ready, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_wr_rvalid got %b exp 0", ext_rvalid); end
    ext_we = 0; ext_wdata = '0;
    #1;
    checks++; if (ext_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ext_rd_cmd got rdy=%b we=%b exp 1/0", ext_ready, mem_we); end
    @(negedge clk);
    ext_valid = 0;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 'h55 || core_rvalid !== 1'b0) begin errors++; $display("FAIL ext_rd_data got v=%b d=%h cv=%b exp 1/55/0", ext_rvalid, ext_rdata, core_rvalid); end
    #1;
    checks++; if (ext_ready !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_outputs got rdy=%b st=%b we=%b exp 0/0/0", ext_ready, core_stall, mem_we); end
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== 'h55) begin errors++; $display("FAIL ext_rd_hold got v=%b d=%h exp 0/55", ext_rvalid, ext_rdata); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 'h10;
    ext_valid = 1; ext_we = 0; ext_addr = 'h20;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (ext_ready !== 1'b0 || core_stall !== 1'b0 || mem_addr !== 'h10) begin errors++; $display("FAIL starve_c%0d got rdy=%b st=%b a=%h exp 0/0/10", i, ext_ready, core_stall, mem_addr); end
      @(negedge clk);
    end
    #1;
    checks++; if (ext_ready !== 1'b1 || core_stall !== 1'b1 || mem_addr !== 'h20) begin errors++; $display("FAIL starve_force got rdy=%b st=%b a=%h exp 1/1/20", ext_ready, core_stall, mem_addr); end
    @(negedge clk);
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 'h55) begin errors++; $display("FAIL starve_force_data got v=%b d=%h exp 1/55", ext_rvalid, ext_rdata); end
    ext_valid = 0;
    #1;
    checks++; if (ext_ready !== 1'b0 || core_stall !== 1'b0 || mem_addr !== 'h10) begin errors++; $display("FAIL starve_after got rdy=%b st=%b a=%h exp 0/0/10", ext_ready, core_stall, mem_addr); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (stat_conflicts !== 4) begin errors++; $display("FAIL stat_conflicts got %0d exp 4", stat_conflicts); end
    checks++; if (stat_forces !== 1) begin errors++; $display("FAIL stat_forces got %0d exp 1", stat_forces); end
`endif
    @(negedge clk);
    core_req = 0;
  endtask

  task automatic test_force_drop();
    // Fresh starvation run: counter was cleared by the previous force
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 'h10;
    ext_valid = 1; ext_we = 0; ext_addr = 'h20;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL drop_c%0d ready got %b exp 0", i, ext_ready); end
      @(negedge clk);
    end
    ext_valid = 0;
    #1;
    checks++; if (ext_ready !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL drop_force got rdy=%b st=%b we=%b a=%h exp 0/0/0/0", ext_ready, core_stall, mem_we, mem_addr); end
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL drop_no_rvalid got %b exp 0", core_rvalid); end
    #1;
    checks++; if (core_stall !== 1'b0 || mem_addr !== 'h10) begin errors++; $display("FAIL drop_back_core got st=%b a=%h exp 0/10", core_stall, mem_addr); end
    @(negedge clk);
    core_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 'h10;
    @(posedge clk);
    #1;
    core_req = 0;
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", core_rvalid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (core_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %b%b exp 00", core_rvalid, ext_rvalid); end
    checks++; if (core_rdata !== '0 || ext_rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got %h/%h exp 0/0", core_rdata, ext_rdata); end
    checks++; if (core_stall !== 1'b0 || ext_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_comb got st=%b rdy=%b we=%b exp 0/0/0", core_stall, ext_ready, mem_we); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== '0) begin errors++; $display("FAIL rstmid_after got v=%b d=%h exp 0/0", core_rvalid, core_rdata); end
    // State must be back in S_CORE: a lone ext request is served at once
    ext_valid = 1; ext_we = 0; ext_addr = 'h20;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got ready=%b exp 1", ext_ready); end
    @(negedge clk);
    ext_valid = 0;
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_ext_rw();
    test_starvation();
    test_force_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
